// File: rtl/step_pulse_receiver_pkg.sv
// Shared definitions for the step/direction receive path: controller states,
// default motor constants and the saturating length-to-steps conversion.
package step_pulse_receiver_pkg;

    localparam int unsigned FCLK_DEFAULT           = 50_000_000;
    localparam int unsigned STEPS_PER_UNIT_DEFAULT = 126;
    localparam int unsigned STALL_CYCLES_DEFAULT   = 5_000_000;
    localparam int unsigned FILTER_CYCLES_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DONE,
        ST_STALL
    } rx_state_t;

    // Length in units times steps per unit, clamped to the 32-bit maximum so
    // a huge request can never wrap around to a small, reachable target.
    function automatic logic [31:0] target_steps_sat(input logic [31:0] len,
                                                     input logic [31:0] spu);
        logic [63:0] prod;
        prod = {32'd0, len} * {32'd0, spu};
        if (prod[63:32] != 32'd0) begin
            return 32'hFFFF_FFFF;
        end
        return prod[31:0];
    endfunction

endpackage

// File: rtl/step_pulse_receiver_if.sv
// Control/status bundle between the cutter control logic (master) and the
// step pulse receiver (slave), including the raw step/direction pins.
interface step_pulse_receiver_if;

    logic        step_in;
    logic        dir_in;
    logic        start;
    logic        abort;
    logic [31:0] target_len;
    logic        busy;
    logic        done;
    logic        stall;
    logic        overrun;
    logic [31:0] step_count;
    logic [31:0] units_fed;

    modport master (
        output step_in, dir_in, start, abort, target_len,
        input  busy, done, stall, overrun, step_count, units_fed
    );

    modport slave (
        input  step_in, dir_in, start, abort, target_len,
        output busy, done, stall, overrun, step_count, units_fed
    );

endinterface

// File: rtl/step_pulse_receiver_filter.sv
// Input conditioning for the step/direction pins: two-flop synchronizers,
// a consecutive-sample deglitcher on the step line and a registered
// rising-edge detector that yields one event per accepted step.
module step_input_filter #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic step_in,
    input  logic dir_in,
    output logic step_event,
    output logic dir_sync
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic             step_meta;
    logic             step_sync;
    logic             dir_meta;
    logic [CNT_W-1:0] agree_cnt;
    logic             level;
    logic             level_d;

    // Bring both asynchronous pins into the clock domain through two flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            dir_meta  <= 1'b0;
            dir_sync  <= 1'b0;
        end else begin
            step_meta <= step_in;
            step_sync <= step_meta;
            dir_meta  <= dir_in;
            dir_sync  <= dir_meta;
        end
    end

    // Accept a new step level only after FILTER_CYCLES differing samples in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            agree_cnt <= '0;
            level     <= 1'b0;
        end else if (step_sync != level) begin
            if (agree_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                level     <= step_sync;
                agree_cnt <= '0;
            end else begin
                agree_cnt <= agree_cnt + 1'b1;
            end
        end else begin
            agree_cnt <= '0;
        end
    end

    // Register a one-cycle event on each rising edge of the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d    <= 1'b0;
            step_event <= 1'b0;
        end else begin
            level_d    <= level;
            step_event <= level & ~level_d;
        end
    end

endmodule

// File: rtl/step_pulse_receiver.sv
// Receive end of the stepper step/direction link: counts the steps actually
// delivered, tracks whole wire length units without a divider, and reports
// done, stall and overrun to the cutter control FSM.
module step_pulse_receiver
    import step_pulse_receiver_pkg::*;
#(
    parameter int unsigned FCLK           = FCLK_DEFAULT,
    parameter int unsigned STEPS_PER_UNIT = STEPS_PER_UNIT_DEFAULT,
    parameter int unsigned STALL_CYCLES   = STALL_CYCLES_DEFAULT,
    parameter int unsigned FILTER_CYCLES  = FILTER_CYCLES_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    step_pulse_receiver_if.slave bus
);

    localparam int unsigned SUB_W = (STEPS_PER_UNIT > 1) ? $clog2(STEPS_PER_UNIT) : 1;

    if (FCLK == 0 || STEPS_PER_UNIT == 0 || STALL_CYCLES < 2 || FILTER_CYCLES == 0) begin : g_param_check
        $error("step_pulse_receiver: invalid parameter value");
    end

    rx_state_t        state;
    logic             busy;
    logic             done;
    logic             stall;
    logic             overrun;
    logic [31:0]      step_count;
    logic [31:0]      units_fed;
    logic [SUB_W-1:0] sub_cnt;
    logic [31:0]      target_steps;
    logic [31:0]      stall_timer;

    logic             step_event;
    logic             dir_sync;
    logic             counted;
    logic [31:0]      count_next;
    logic [31:0]      units_next;
    logic [SUB_W-1:0] sub_next;

    step_input_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .step_in    (bus.step_in),
        .dir_in     (bus.dir_in),
        .step_event (step_event),
        .dir_sync   (dir_sync)
    );

    // Work out what the counters become if this cycle's step is counted;
    // reverse steps at zero are dropped so the count never underflows.
    always_comb begin
        counted    = step_event && (dir_sync || (step_count != 32'd0));
        count_next = step_count;
        units_next = units_fed;
        sub_next   = sub_cnt;
        if (dir_sync) begin
            count_next = step_count + 32'd1;
            if (sub_cnt == SUB_W'(STEPS_PER_UNIT - 1)) begin
                sub_next   = '0;
                units_next = units_fed + 32'd1;
            end else begin
                sub_next = sub_cnt + 1'b1;
            end
        end else begin
            count_next = step_count - 32'd1;
            if (sub_cnt == '0) begin
                sub_next   = SUB_W'(STEPS_PER_UNIT - 1);
                units_next = units_fed - 32'd1;
            end else begin
                sub_next = sub_cnt - 1'b1;
            end
        end
    end

    // Controller: abort beats start, start beats a same-cycle step, and a
    // counted step beats a same-cycle stall timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            stall        <= 1'b0;
            overrun      <= 1'b0;
            step_count   <= 32'd0;
            units_fed    <= 32'd0;
            sub_cnt      <= '0;
            target_steps <= 32'd0;
            stall_timer  <= 32'd0;
        end else begin
            done <= 1'b0;
            if (bus.abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                stall <= 1'b0;
            end else if (bus.start && (state != ST_ARMED)) begin
                step_count   <= 32'd0;
                units_fed    <= 32'd0;
                sub_cnt      <= '0;
                overrun      <= 1'b0;
                stall        <= 1'b0;
                stall_timer  <= 32'd0;
                target_steps <= target_steps_sat(bus.target_len, 32'(STEPS_PER_UNIT));
                if (bus.target_len == 32'd0) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_ARMED;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (counted) begin
                            step_count  <= count_next;
                            units_fed   <= units_next;
                            sub_cnt     <= sub_next;
                            stall_timer <= 32'd0;
                            if (dir_sync && (count_next == target_steps)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else if (stall_timer == 32'(STALL_CYCLES - 1)) begin
                            state <= ST_STALL;
                            stall <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            stall_timer <= stall_timer + 32'd1;
                        end
                    end
                    ST_DONE: begin
                        if (counted) begin
                            step_count <= count_next;
                            units_fed  <= units_next;
                            sub_cnt    <= sub_next;
                            overrun    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.stall      = stall;
    assign bus.overrun    = overrun;
    assign bus.step_count = step_count;
    assign bus.units_fed  = units_fed;

endmodule

// File: tb/tb_step_pulse_receiver.sv
// Self-checking bench for step_pulse_receiver: a table of whole feed jobs,
// hand-written corner sequences, and a randomized phase against a
// transaction-level model of the receiver's rules.
module tb_step_pulse_receiver;

    localparam int SPU   = 126;
    localparam int STALL = 300;
    localparam int FILT  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_DONE  = 2;
    localparam int M_STALL = 3;

    typedef struct {
        logic [31:0] target_len;
        int          n_fwd;
        int          n_rev;
        logic [31:0] exp_count;
        logic [31:0] exp_units;
        logic        exp_busy;
        logic        exp_overrun;
        int          exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   done_total = 0;
    int   done_busy_cnt = 0;

    int      m_state;
    longint  m_count;
    longint  m_tgt;
    logic    m_overrun;
    int      m_done;
    int      m_quiet;

    vec_t vecs[5];

    always #5 clk = ~clk;

    step_pulse_receiver_if bus();

    step_pulse_receiver #(
        .FCLK           (50_000_000),
        .STEPS_PER_UNIT (SPU),
        .STALL_CYCLES   (STALL),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count done pulses and note any done that is seen together with busy.
    always @(negedge clk) begin
        if (bus.done) begin
            done_total++;
            if (bus.busy) done_busy_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] len);
        bus.target_len = len;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse(input logic dir, input int high);
        bus.dir_in  = dir;
        bus.step_in = 1'b1;
        tick(high);
        bus.step_in = 1'b0;
        tick(8);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int base;
        do_abort();
        base = done_total;
        do_start(v.target_len);
        repeat (v.n_fwd) pulse(1'b1, 8);
        repeat (v.n_rev) pulse(1'b0, 8);
        tick(4);
        checkOutput($sformatf("vec%0d_count", idx), bus.step_count, v.exp_count);
        checkOutput($sformatf("vec%0d_units", idx), bus.units_fed, v.exp_units);
        checkOutput($sformatf("vec%0d_busy", idx), 32'(bus.busy), 32'(v.exp_busy));
        checkOutput($sformatf("vec%0d_overrun", idx), 32'(bus.overrun), 32'(v.exp_overrun));
        checkOutput($sformatf("vec%0d_done", idx), 32'(done_total - base), 32'(v.exp_done));
    endtask

    // Reference model: one call per delivered step or request.
    task automatic m_start(input logic [31:0] len);
        longint prod;
        if (m_state == M_ARMED) begin
            m_quiet++;
            return;
        end
        prod = longint'(len) * SPU;
        m_tgt = (prod > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : prod;
        m_count = 0;
        m_overrun = 1'b0;
        m_quiet = 0;
        if (len == 0) begin
            m_state = M_DONE;
            m_done++;
        end else begin
            m_state = M_ARMED;
        end
    endtask

    task automatic m_step(input logic dir);
        if ((m_state == M_ARMED || m_state == M_DONE) && (dir || m_count > 0)) begin
            m_count = dir ? m_count + 1 : m_count - 1;
            m_quiet = 0;
            if (m_state == M_DONE) begin
                m_overrun = 1'b1;
            end else if (dir && m_count == m_tgt) begin
                m_state = M_DONE;
                m_done++;
            end
        end else if (m_state == M_ARMED) begin
            m_quiet++;
        end
    endtask

    task automatic check_model(input int op, input int base);
        checkOutput($sformatf("rnd%0d_count", op), bus.step_count, 32'(m_count));
        checkOutput($sformatf("rnd%0d_units", op), bus.units_fed, 32'(m_count / SPU));
        checkOutput($sformatf("rnd%0d_busy", op), 32'(bus.busy), 32'(m_state == M_ARMED));
        checkOutput($sformatf("rnd%0d_stall", op), 32'(bus.stall), 32'(m_state == M_STALL));
        checkOutput($sformatf("rnd%0d_overrun", op), 32'(bus.overrun), 32'(m_overrun));
        checkOutput($sformatf("rnd%0d_done", op), 32'(done_total - base), 32'(m_done));
    endtask

    initial begin
        int base;
        int r;
        int n;
        logic d;
        logic [31:0] len;

        vecs[0] = '{32'd1, 126, 0,  32'd126, 32'd1, 1'b0, 1'b0, 1};
        vecs[1] = '{32'd2, 252, 0,  32'd252, 32'd2, 1'b0, 1'b0, 1};
        vecs[2] = '{32'd1, 10,  12, 32'd0,   32'd0, 1'b1, 1'b0, 0};
        vecs[3] = '{32'd1, 128, 0,  32'd128, 32'd1, 1'b0, 1'b1, 1};
        vecs[4] = '{32'd3, 130, 5,  32'd125, 32'd0, 1'b1, 1'b0, 0};

        reset = 1'b1;
        bus.step_in = 1'b0;
        bus.dir_in = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.target_len = 32'd0;
        tick(3);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_stall", 32'(bus.stall), 32'd0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("reset_count", bus.step_count, 32'd0);
        checkOutput("reset_units", bus.units_fed, 32'd0);
        reset = 1'b0;
        tick(1);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        $display("[TB] latency and glitch filter");
        do_abort();
        do_start(32'd5);
        bus.dir_in = 1'b1;
        bus.step_in = 1'b1;
        tick(7);
        checkOutput("latency_early", bus.step_count, 32'd0);
        tick(1);
        checkOutput("latency_exact", bus.step_count, 32'd1);
        bus.step_in = 1'b0;
        tick(8);
        repeat (3) pulse(1'b1, FILT - 1);
        tick(4);
        checkOutput("glitch_ignored", bus.step_count, 32'd1);
        pulse(1'b1, FILT);
        tick(4);
        checkOutput("min_width_counted", bus.step_count, 32'd2);

        $display("[TB] saturated target");
        do_abort();
        base = done_total;
        do_start(32'd34087043);
        repeat (125) pulse(1'b1, 8);
        tick(4);
        checkOutput("sat_count", bus.step_count, 32'd125);
        checkOutput("sat_busy", 32'(bus.busy), 32'd1);
        checkOutput("sat_no_done", 32'(done_total - base), 32'd0);

        $display("[TB] stall, start with abort, restart");
        do_abort();
        do_start(32'd5);
        repeat (3) pulse(1'b1, 8);
        tick(STALL - 40);
        checkOutput("stall_not_yet", 32'(bus.stall), 32'd0);
        tick(60);
        checkOutput("stall_level", 32'(bus.stall), 32'd1);
        checkOutput("stall_busy", 32'(bus.busy), 32'd0);
        checkOutput("stall_count", bus.step_count, 32'd3);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.target_len = 32'd7;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick(1);
        checkOutput("abort_wins_stall", 32'(bus.stall), 32'd0);
        checkOutput("abort_wins_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_holds_count", bus.step_count, 32'd3);
        do_start(32'd5);
        checkOutput("restart_busy", 32'(bus.busy), 32'd1);
        checkOutput("restart_count", bus.step_count, 32'd0);

        $display("[TB] zero target");
        do_abort();
        base = done_total;
        do_start(32'd0);
        checkOutput("zero_done_now", 32'(bus.done), 32'd1);
        checkOutput("zero_busy", 32'(bus.busy), 32'd0);
        tick(2);
        checkOutput("zero_done_once", 32'(done_total - base), 32'd1);

        $display("[TB] reset mid count");
        do_abort();
        do_start(32'd1);
        repeat (20) pulse(1'b1, 8);
        reset = 1'b1;
        tick(1);
        checkOutput("midreset_count", bus.step_count, 32'd0);
        checkOutput("midreset_units", bus.units_fed, 32'd0);
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] randomized phase");
        m_state = M_IDLE;
        m_count = 0;
        m_tgt = 0;
        m_overrun = 1'b0;
        m_done = 0;
        m_quiet = 0;
        base = done_total;
        for (int op = 0; op < 120; op++) begin
            r = $urandom_range(0, 99);
            if (m_state == M_ARMED && m_quiet >= 4) r = 0;
            if (r < 45 || (r < 60 && m_state == M_ARMED && m_count == 0)) begin
                pulse(1'b1, $urandom_range(FILT, 10));
                m_step(1'b1);
            end else if (r < 60) begin
                pulse(1'b0, $urandom_range(FILT, 10));
                m_step(1'b0);
            end else if (r < 75) begin
                n = $urandom_range(5, 40);
                d = 1'b1;
                for (int k = 0; k < n; k++) begin
                    pulse(d, 8);
                    m_step(d);
                end
            end else if (r < 85) begin
                len = ($urandom_range(0, 7) == 0) ? 32'd34087043 + $urandom_range(0, 100)
                                                  : 32'($urandom_range(0, 2));
                do_start(len);
                m_start(len);
            end else if (r < 90) begin
                do_abort();
                m_state = M_IDLE;
                m_quiet = 0;
            end else if (r < 95) begin
                tick(STALL + 20);
                if (m_state == M_ARMED) m_state = M_STALL;
            end else begin
                tick($urandom_range(1, 20));
                if (m_state == M_ARMED) m_quiet++;
            end
            tick(2);
            check_model(op, base);
        end

        checkOutput("done_with_busy", 32'(done_busy_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_pulse_receiver.md
Name: step_pulse_receiver

Overview:
Receive end of the stepper step/direction interface. Samples a toggling step line and its direction line (looped back from the motor driver or taken from a feed-roller pulse sensor), deglitches them, and counts the steps actually delivered. Converts the step count to wire length units and flags done, stall and overrun to the cutter control FSM. Sits between the driver pins and the control logic, in parallel with the step generator.

Parameters:
FCLK, 50000000, clock frequency in Hz (documentation and timeout derivation only)
STEPS_PER_UNIT, 126, steps per wire length unit
STALL_CYCLES, 5000000, clk cycles with no counted step while ARMED before stall (100 ms at default)
FILTER_CYCLES, 4, consecutive identical synchronized samples needed to accept a new step level (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
step_in  in  1  asynchronous step line; each rising edge is one step
dir_in  in  1  asynchronous direction; 1 = forward (feed), 0 = reverse
start  in  1  one-cycle request: clear counters, load target, arm
abort  in  1  one-cycle request: return to IDLE
target_len  in  32  desired length in units, sampled on accepted start
busy  out  1  high while ARMED
done  out  1  one-cycle pulse when target reached
stall  out  1  level, high in STALL state
overrun  out  1  sticky: a step was counted while in DONE
step_count  out  32  net steps since last start (unsigned)
units_fed  out  32  step_count / STEPS_PER_UNIT (floor)

Behaviour:
- Reset: state IDLE; busy, done, stall, overrun = 0; step_count, units_fed, sub-unit counter, stall timer = 0; synchronizer and filter initialized to level 0.
- Input path: step_in and dir_in each pass through 2 flops. The filtered step level changes only after FILTER_CYCLES consecutive synchronized samples that differ from the current filtered level.
- Edge: a rising edge of the filtered level gives one step event. Direction is the synchronized dir value in the event cycle.
- Latency: counters update 2 + FILTER_CYCLES + 1 clk edges after the first clk edge that samples step_in high.
- Counting happens only in ARMED and DONE. Forward: step_count +1. Reverse: step_count -1; a reverse step at step_count = 0 is ignored.
- units_fed is maintained incrementally with a sub-unit counter 0..STEPS_PER_UNIT-1 and carry/borrow. No divider.
- Target: target_steps = target_len * STEPS_PER_UNIT, computed on start and saturated at 32'hFFFFFFFF.
- States:
  - IDLE: start -> ARMED.
  - ARMED: busy = 1.
    - A forward event making step_count == target_steps -> DONE, with done pulsed that cycle.
    - If the stall timer reaches STALL_CYCLES-1 with no event -> STALL.
  - DONE: start -> ARMED. A counted step sets overrun.
  - STALL: stall = 1. start -> ARMED.
- target_len = 0: start -> DONE directly, done pulsed on the next cycle, busy stays 0.
- Accepted start (in IDLE, DONE or STALL): clear step_count, units_fed, sub-unit counter, overrun and stall timer. start while ARMED is ignored.
- abort: from any state -> IDLE next cycle; clears stall; counters hold their values.
- Simultaneous events:
  - start and abort together: abort wins.
  - Step event in the same cycle the timer expires: the event wins and the timer resets.
  - start in the same cycle as a step event: start wins and the event is discarded.
- Stall timer: cleared on entering ARMED and on every counted event; counts only in ARMED.
- Reset asserted mid-operation: immediate return to the reset state on the next clk edge.

Decomposition:
- Shared package (motor_pkg): state enum (IDLE, ARMED, DONE, STALL), STEPS_PER_UNIT default, FCLK default. The step generator uses the same constants.
- One natural sub-module: step_input_filter (2-flop synchronizer + FILTER_CYCLES deglitch + rising-edge detect), instantiated for step with dir taken through its synchronizer only.

Test Plan:
- start, target_len=1, 126 forward clean pulses (period 1000 clk) -> done pulses once at step 126; step_count=126; units_fed=1; busy falls same cycle.
- start, target_len=2, 3 glitches of FILTER_CYCLES-1 cycles plus 252 clean pulses -> glitches not counted; done at step 252.
- start, target_len=1, 10 forward pulses, then dir=0 and 12 reverse pulses -> step_count=0 (last 2 ignored); no done.
- start, target_len=5, 3 pulses, then idle 5000000 cycles -> stall=1, busy=0, step_count=3; a new start clears stall and counters.
- Reach DONE with target_len=1, then 2 more pulses -> overrun=1, step_count=128, units_fed=1.
- start and abort same cycle -> state IDLE, busy=0. target_len=0 -> done one cycle after start, no busy. reset mid-count -> all outputs 0.
